// File: rtl/full_adder_structural.sv
// One-bit full adder built from two gate-level half adders and an OR primitive,
// with a reset-cleared registered copy of sum and carry for synchronous consumers.

module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    xor u_xor (s, a, b);
    and u_and (c, a, b);

endmodule

module full_adder_structural (
    input  logic clk,
    input  logic rst_n,
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic S,
    output logic Cout,
    output logic S_q,
    output logic Cout_q
);

    logic p;
    logic g0;
    logic g1;

    half_adder u_ha0 (
        .a (A),
        .b (B),
        .s (p),
        .c (g0)
    );

    half_adder u_ha1 (
        .a (p),
        .b (Cin),
        .s (S),
        .c (g1)
    );

    or u_or (Cout, g0, g1);

    // Sample stage only; the combinational path above never depends on clk or rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            S_q    <= 1'b0;
            Cout_q <= 1'b0;
        end else begin
            S_q    <= S;
            Cout_q <= Cout;
        end
    end

endmodule

// File: tb/tb_full_adder_structural.sv
// Bench for full_adder_structural: truth-table vectors, reset/latency sequences,
// and random traffic checked against plain-arithmetic expectations.

module tb_full_adder_structural;

    logic clk;
    logic rst_n;
    logic a, b, cin;
    logic s, cout, s_q, cout_q;
    logic clk_en;

    int n_pass;
    int n_total;

    full_adder_structural dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .A      (a),
        .B      (b),
        .Cin    (cin),
        .S      (s),
        .Cout   (cout),
        .S_q    (s_q),
        .Cout_q (cout_q)
    );

    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    typedef struct {
        logic [2:0] abc;
        logic       s;
        logic       c;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic act, input logic exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        else
            n_pass++;
    endtask

    task automatic drive(input logic [2:0] v);
        a   = v[2];
        b   = v[1];
        cin = v[0];
    endtask

    initial begin
        logic [1:0] sum;
        logic [1:0] expect_q;
        logic [2:0] r;
        bit seen0, seen3;

        n_pass  = 0;
        n_total = 0;
        clk     = 1'b0;
        clk_en  = 1'b0;
        rst_n   = 1'b0;
        drive(3'b000);

        vecs[0] = '{3'b000, 1'b0, 1'b0};
        vecs[1] = '{3'b001, 1'b1, 1'b0};
        vecs[2] = '{3'b010, 1'b1, 1'b0};
        vecs[3] = '{3'b011, 1'b0, 1'b1};
        vecs[4] = '{3'b100, 1'b1, 1'b0};
        vecs[5] = '{3'b101, 1'b0, 1'b1};
        vecs[6] = '{3'b110, 1'b0, 1'b1};
        vecs[7] = '{3'b111, 1'b1, 1'b1};

        #2;
        chk("reset_s_q", s_q, 1'b0);
        chk("reset_cout_q", cout_q, 1'b0);

        // Exhaustive combinational table with the clock idle.
        seen0 = 0;
        seen3 = 0;
        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].abc);
            #25;
            sum = 2'(vecs[i].abc[2]) + 2'(vecs[i].abc[1]) + 2'(vecs[i].abc[0]);
            chk($sformatf("tbl_s_%b", vecs[i].abc), s, vecs[i].s);
            chk($sformatf("tbl_cout_%b", vecs[i].abc), cout, vecs[i].c);
            chk($sformatf("arith_s_%b", vecs[i].abc), s, sum[0]);
            chk($sformatf("arith_cout_%b", vecs[i].abc), cout, sum[1]);
            if ({cout, s} == 2'd0) seen0 = 1;
            if ({cout, s} == 2'd3) seen3 = 1;
        end
        chk("arith_seen_0", seen0, 1'b1);
        chk("arith_seen_3", seen3, 1'b1);

        // Unknown inputs, then recovery to a known vector.
        a = 1'bx; b = 1'bx; cin = 1'bx;
        #10;
        drive(3'b000);
        #1;
        chk("x_recover_s", s, 1'b0);
        chk("x_recover_cout", cout, 1'b0);

        // Reset asserted mid-operation between edges.
        rst_n  = 1'b1;
        clk_en = 1'b1;
        drive(3'b111);
        repeat (3) @(posedge clk);
        #1;
        chk("run_s_q_111", s_q, 1'b1);
        chk("run_cout_q_111", cout_q, 1'b1);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_s_q", s_q, 1'b0);
        chk("async_rst_cout_q", cout_q, 1'b0);
        chk("async_rst_s_comb", s, 1'b1);
        chk("async_rst_cout_comb", cout, 1'b1);
        @(posedge clk);
        #1;
        chk("held_rst_s_q", s_q, 1'b0);
        chk("held_rst_cout_q", cout_q, 1'b0);

        // Release and single-cycle latency.
        @(negedge clk);
        rst_n = 1'b1;
        drive(3'b011);
        @(posedge clk);
        #1;
        chk("lat_011_s_q", s_q, 1'b0);
        chk("lat_011_cout_q", cout_q, 1'b1);
        drive(3'b100);
        #1;
        chk("lat_pre_s_q", s_q, 1'b0);
        chk("lat_pre_cout_q", cout_q, 1'b1);
        @(posedge clk);
        #1;
        chk("lat_100_s_q", s_q, 1'b1);
        chk("lat_100_cout_q", cout_q, 1'b0);

        // Random traffic against a plain-arithmetic model.
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            r = 3'($urandom_range(0, 7));
            drive(r);
            expect_q = 2'(r[2]) + 2'(r[1]) + 2'(r[0]);
            #1;
            chk("rnd_s", s, expect_q[0]);
            chk("rnd_cout", cout, expect_q[1]);
            @(posedge clk);
            #1;
            chk("rnd_s_q", s_q, expect_q[0]);
            chk("rnd_cout_q", cout_q, expect_q[1]);
        end

        clk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
